card_bbox_finder: RTL and testbench
===================================

# card_bbox_finder

Streaming bounding-box detector that sits directly upstream of the card isolator. It classifies each incoming RGB565 camera pixel as card (bright) or background by luminance threshold, and accumulates the min/max column and row of card pixels over one frame. At frame end it validates the box and publishes left/right/top/bottom edges together with a one-cycle `start_flag` pulse, which triggers the isolator's frame-buffer scan.

## Interface
- `WIDTH`, 240, frame width in pixels
- `HEIGHT`, 320, frame height in pixels
- `LUMA_THRESH`, 150, minimum 8-bit luma for a bright pixel
- `MIN_RUN`, 4, consecutive bright pixels in a row needed to qualify (run filter only)
- `MIN_W`, 32, minimum accepted box width in pixels
- `MIN_H`, 32, minimum accepted box height in pixels

Ports:
- `clk_in`  input  1  system clock
- `rst_in`  input  1  reset, asynchronous, active-low
- `frame_start_in`  input  1  one-cycle pulse before the first pixel of a frame
- `frame_end_in`  input  1  one-cycle pulse after the last pixel of a frame
- `pixel_valid_in`  input  1  pixel/coordinate inputs valid this cycle
- `hcount_in`  input  $clog2(WIDTH)  pixel column
- `vcount_in`  input  $clog2(HEIGHT)  pixel row
- `pixel_data_in`  input  16  RGB565 pixel
- `busy_in`  input  1  downstream isolator busy; do not publish
- `left_edge`, `right_edge`  output  $clog2(WIDTH)  box columns, inclusive
- `top_edge`, `bot_edge`  output  $clog2(HEIGHT)  box rows, inclusive
- `start_flag`  output  1  one-cycle pulse when new edges are published
- `box_found`  output  1  level; the last completed frame produced a valid box
- `drop_cnt`  output  8  saturating count of valid boxes dropped because of `busy_in`

## Operation
- Luma is computed as `{R,1'b0} + G + {B,1'b0}`, 8 bits, maximum 187. A pixel is bright when luma ≥ `LUMA_THRESH`.
- FSM states:
  - IDLE: `frame_start_in` clears the accumulators and moves to ACCUM.
  - ACCUM: each qualifying pixel updates min_x/max_x/min_y/max_y. The delayed `frame_end_in` moves to CHECK. A new `frame_start_in` re-clears the accumulators and stays in ACCUM, discarding the partial frame.
  - CHECK: valid = (max_x ≥ min_x) && (max_x−min_x+1 ≥ `MIN_W`) && (max_y−min_y+1 ≥ `MIN_H`). Compute the widths one bit wider to avoid wrap. Go to PUBLISH.
  - PUBLISH: one cycle, then IDLE.
    - valid && !`busy_in`: latch the edges, pulse `start_flag`, set `box_found`=1.
    - valid && `busy_in`: edges unchanged, no pulse, `drop_cnt` +1 (saturates at 255), `box_found`=1.
    - invalid: edges unchanged, no pulse, `box_found`=0.
- Accumulators clear to min=all-ones, max=0. An empty frame therefore fails the max ≥ min test.
- `frame_end_in` in IDLE, and pixels outside ACCUM, are ignored.
- `frame_end_in` and `frame_start_in` in the same cycle: the end is processed first. The start is lost, and the next frame is accumulated only from the following `frame_start_in`.
- Edges hold their last published values indefinitely.
- Reset (any time, including mid-frame): state IDLE, all edges 0, `start_flag` 0, `box_found` 0, `drop_cnt` 0, accumulators cleared.

## Timing
- Two-stage pixel pipeline:
  - Stage 1 registers the bright flag and the coordinates.
  - Stage 2 updates the run counter and the extents.
- `frame_end_in` is delayed two cycles to align with the pipeline.
- If `frame_end_in` is sampled high at edge N: CHECK occupies cycle N+3, and the edges plus `start_flag` are high for exactly the cycle following edge N+4.
- `busy_in` is sampled in the PUBLISH cycle only.
- Throughput: one pixel per clock, with no back-pressure on the pixel input.

## Configuration
- `CARD_BBOX_RUN_FILTER_EN` defined:
  - A per-row run counter resets on `hcount_in`==0 and on any dark pixel, and saturates at `MIN_RUN`.
  - A pixel qualifies only once the run reaches `MIN_RUN`. min_x is then updated with `hcount`−`MIN_RUN`+1.
  - Isolated specks are rejected.
- Undefined: every bright pixel qualifies directly, and there is no run counter logic.

## Structure
- Shared package `card_pkg`:
  - FSM state enum (IDLE, ACCUM, CHECK, PUBLISH).
  - RGB565 field-extraction constants.
  - Default WIDTH/HEIGHT localparams, shared with the isolator.
- Sub-module `card_luma_thresh`: stage-1 classifier (RGB565 → luma → bright flag, plus registered coordinates).

## Test plan
- 240×320 frame, dark except an `16'hFFFF` rectangle at x 40..199, y 60..259 → `start_flag` pulse at N+4 with left=40, right=199, top=60, bot=259, `box_found`=1.
- Same frame plus a single bright pixel at (5,5):
  - Filter enabled, `MIN_RUN`=4 → left=40, top=60.
  - Filter disabled → left=5, top=5.
- All-dark frame after a valid frame → no pulse, `box_found`=0, edges hold 40/199/60/259.
- Valid frame with `busy_in`=1 during PUBLISH → no pulse, edges unchanged, `drop_cnt`=1. A second such frame → `drop_cnt`=2.
- 10×10 bright square (below `MIN_W`/`MIN_H`) → no pulse, `box_found`=0.
- `rst_in` asserted mid-ACCUM → all outputs 0 immediately. A second `frame_start_in` mid-frame discards earlier pixels: only the box from the second start is reported.

Source files
------------

// File: rtl/card_pkg.sv
// Shared definitions for the card detection path: FSM states, RGB565 field
// positions, default frame geometry and the luma helper.
package card_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CHECK,
    PUBLISH
  } card_state_t;

  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  localparam int unsigned CARD_WIDTH  = 240;
  localparam int unsigned CARD_HEIGHT = 320;

  // 2R + G + 2B on the raw 5/6/5 fields; peaks at 187, so 8 bits never wrap
  function automatic logic [7:0] rgb565_luma(input logic [15:0] px);
    logic [7:0] r2, g1, b2;
    r2 = {2'b00, px[RGB_R_MSB:RGB_R_LSB], 1'b0};
    g1 = {2'b00, px[RGB_G_MSB:RGB_G_LSB]};
    b2 = {2'b00, px[RGB_B_MSB:RGB_B_LSB], 1'b0};
    return r2 + g1 + b2;
  endfunction

endpackage

// File: rtl/card_luma_thresh.sv
// Stage-1 pixel classifier: RGB565 -> luma -> bright flag, registered together
// with the pixel coordinates.
module card_luma_thresh
  import card_pkg::*;
#(
  parameter int unsigned XW          = 8,
  parameter int unsigned YW          = 9,
  parameter logic [7:0]  LUMA_THRESH = 8'd150
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          pixel_valid_in,
  input  logic [XW-1:0] hcount_in,
  input  logic [YW-1:0] vcount_in,
  input  logic [15:0]   pixel_data_in,
  output logic          s1_valid,
  output logic          s1_bright,
  output logic [XW-1:0] s1_x,
  output logic [YW-1:0] s1_y
);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid  <= 1'b0;
      s1_bright <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
    end else begin
      s1_valid  <= pixel_valid_in;
      s1_bright <= rgb565_luma(pixel_data_in) >= LUMA_THRESH;
      s1_x      <= hcount_in;
      s1_y      <= vcount_in;
    end
  end

endmodule

// File: rtl/card_bbox_finder.sv
// Per-frame bounding box of bright pixels, validated and published with a
// start_flag pulse. Define CARD_BBOX_RUN_FILTER_EN to require MIN_RUN bright pixels in a row.
module card_bbox_finder
  import card_pkg::*;
#(
  parameter int unsigned WIDTH       = CARD_WIDTH,
  parameter int unsigned HEIGHT      = CARD_HEIGHT,
  parameter int unsigned LUMA_THRESH = 150,
  parameter int unsigned MIN_RUN     = 4,
  parameter int unsigned MIN_W       = 32,
  parameter int unsigned MIN_H       = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      frame_start_in,
  input  logic                      frame_end_in,
  input  logic                      pixel_valid_in,
  input  logic [$clog2(WIDTH)-1:0]  hcount_in,
  input  logic [$clog2(HEIGHT)-1:0] vcount_in,
  input  logic [15:0]               pixel_data_in,
  input  logic                      busy_in,
  output logic [$clog2(WIDTH)-1:0]  left_edge,
  output logic [$clog2(WIDTH)-1:0]  right_edge,
  output logic [$clog2(HEIGHT)-1:0] top_edge,
  output logic [$clog2(HEIGHT)-1:0] bot_edge,
  output logic                      start_flag,
  output logic                      box_found,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  card_state_t   state, state_nx;
  logic          s1_valid, s1_bright;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          fe_d1, fe_d2;
  logic          frame_clr;
  logic          qual;
  logic [XW-1:0] qual_min_x;
  logic [XW-1:0] min_x, max_x;
  logic [YW-1:0] min_y, max_y;
  logic [XW:0]   box_w;
  logic [YW:0]   box_h;
  logic          box_valid;

  card_luma_thresh #(
    .XW          (XW),
    .YW          (YW),
    .LUMA_THRESH (8'(LUMA_THRESH))
  ) u_luma (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .pixel_data_in  (pixel_data_in),
    .s1_valid       (s1_valid),
    .s1_bright      (s1_bright),
    .s1_x           (s1_x),
    .s1_y           (s1_y)
  );

  // A start coinciding with an end, or while an end is still in the pipe, is dropped
  assign frame_clr = frame_start_in && !frame_end_in && !fe_d1 && !fe_d2 &&
                     ((state == IDLE) || (state == ACCUM));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fe_d1 <= 1'b0;
      fe_d2 <= 1'b0;
    end else begin
      fe_d1 <= frame_end_in && (state == ACCUM);
      fe_d2 <= fe_d1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_clr) state_nx = ACCUM;
      ACCUM:   if (fe_d2)     state_nx = CHECK;
      CHECK:   state_nx = PUBLISH;
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef CARD_BBOX_RUN_FILTER_EN
  localparam int unsigned RW = $clog2(MIN_RUN + 1);
  logic [RW-1:0] run_cnt, run_nx;

  always_comb begin
    run_nx = run_cnt;
    if (s1_valid) begin
      if (!s1_bright)          run_nx = '0;
      else if (s1_x == '0)     run_nx = RW'(1);
      else if (run_cnt < RW'(MIN_RUN)) run_nx = run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) run_cnt <= '0;
    else         run_cnt <= run_nx;
  end

  // The qualifying pixel closes the run, so the box starts MIN_RUN-1 columns earlier
  assign qual       = s1_valid && s1_bright && (run_nx == RW'(MIN_RUN));
  assign qual_min_x = s1_x - XW'(MIN_RUN - 1);
`else
  assign qual       = s1_valid && s1_bright;
  assign qual_min_x = s1_x;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
    end else if (frame_clr) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
    end else if ((state == ACCUM) && qual) begin
      if (qual_min_x < min_x) min_x <= qual_min_x;
      if (s1_x > max_x)       max_x <= s1_x;
      if (s1_y < min_y)       min_y <= s1_y;
      if (s1_y > max_y)       max_y <= s1_y;
    end
  end

  assign box_w = {1'b0, max_x} - {1'b0, min_x} + (XW+1)'(1);
  assign box_h = {1'b0, max_y} - {1'b0, min_y} + (YW+1)'(1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      box_valid <= 1'b0;
    end else if (state == CHECK) begin
      box_valid <= (max_x >= min_x) &&
                   (box_w >= (XW+1)'(MIN_W)) &&
                   (box_h >= (YW+1)'(MIN_H));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      left_edge  <= '0;
      right_edge <= '0;
      top_edge   <= '0;
      bot_edge   <= '0;
      start_flag <= 1'b0;
      box_found  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      start_flag <= 1'b0;
      if (state == PUBLISH) begin
        box_found <= box_valid;
        if (box_valid && !busy_in) begin
          left_edge  <= min_x;
          right_edge <= max_x;
          top_edge   <= min_y;
          bot_edge   <= max_y;
          start_flag <= 1'b1;
        end else if (box_valid && (drop_cnt != '1)) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_card_bbox_finder.sv
// Directed bench for card_bbox_finder: a frame-level bounding-box model checked
// against the outputs every cycle, plus literal expectations after each frame.
module tb_card_bbox_finder;

  localparam int WIDTH   = 240;
  localparam int HEIGHT  = 320;
  localparam int MIN_RUN = 4;
  localparam int MIN_W   = 32;
  localparam int MIN_H   = 32;
  localparam logic [15:0] DARK   = 16'h0000;
  localparam logic [15:0] BRIGHT = 16'hFFFF;
  localparam logic [15:0] L150   = 16'hFB5F;  // R=31 G=26 B=31 -> 150
  localparam logic [15:0] L149   = 16'hFB3F;  // R=31 G=25 B=31 -> 149

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        frame_end_in = 1'b0;
  logic        pixel_valid_in = 1'b0;
  logic [7:0]  hcount_in = '0;
  logic [8:0]  vcount_in = '0;
  logic [15:0] pixel_data_in = '0;
  logic        busy_in = 1'b0;
  logic [7:0]  left_edge, right_edge;
  logic [8:0]  top_edge, bot_edge;
  logic        start_flag, box_found;
  logic [7:0]  drop_cnt;

  always #5 clk_in = ~clk_in;

  card_bbox_finder #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LUMA_THRESH(150),
    .MIN_RUN(MIN_RUN), .MIN_W(MIN_W), .MIN_H(MIN_H)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
    .pixel_valid_in(pixel_valid_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_data_in(pixel_data_in), .busy_in(busy_in),
    .left_edge(left_edge), .right_edge(right_edge),
    .top_edge(top_edge), .bot_edge(bot_edge),
    .start_flag(start_flag), .box_found(box_found), .drop_cnt(drop_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // expected outputs
  logic [7:0] e_left = '0, e_right = '0;
  logic [8:0] e_top = '0, e_bot = '0;
  logic       e_start = 1'b0, e_found = 1'b0;
  logic [7:0] e_drop = '0;

  // frame model: extremes of qualifying pixels since the last accepted start
  int m_minx, m_maxx, m_miny, m_maxy, m_run;
  bit m_accum;

  always @(negedge clk_in) begin
    if (chk_en) begin
      total++;
      if ({left_edge, right_edge, top_edge, bot_edge, start_flag, box_found, drop_cnt} !==
          {e_left, e_right, e_top, e_bot, e_start, e_found, e_drop}) begin
        bad++;
        $display("FAIL cycle t=%0t got L=%0d R=%0d T=%0d B=%0d sf=%0b bf=%0b drop=%0d want L=%0d R=%0d T=%0d B=%0d sf=%0b bf=%0b drop=%0d",
                 $time, left_edge, right_edge, top_edge, bot_edge, start_flag, box_found, drop_cnt,
                 e_left, e_right, e_top, e_bot, e_start, e_found, e_drop);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_box(input string name, input int l, input int r, input int t, input int b,
                         input bit found);
    chk({name, "_left"},  32'(left_edge),  32'(l));
    chk({name, "_right"}, 32'(right_edge), 32'(r));
    chk({name, "_top"},   32'(top_edge),   32'(t));
    chk({name, "_bot"},   32'(bot_edge),   32'(b));
    chk({name, "_found"}, 32'(box_found),  32'(found));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic m_clear();
    m_minx = 1 << 30;
    m_maxx = -1;
    m_miny = 1 << 30;
    m_maxy = -1;
  endtask

  task automatic model_px(input int x, input int y, input logic [15:0] d);
    int  l, cx;
    bit  br, q;
    l  = 2 * int'(d[15:11]) + int'(d[10:5]) + 2 * int'(d[4:0]);
    br = (l >= 150);
    if (!br)         m_run = 0;
    else if (x == 0) m_run = 1;
    else             m_run++;
`ifdef CARD_BBOX_RUN_FILTER_EN
    q  = br && (m_run >= MIN_RUN);
    cx = x - MIN_RUN + 1;
`else
    q  = br;
    cx = x;
`endif
    if (m_accum && q) begin
      if (cx < m_minx) m_minx = cx;
      if (x > m_maxx)  m_maxx = x;
      if (y < m_miny)  m_miny = y;
      if (y > m_maxy)  m_maxy = y;
    end
  endtask

  task automatic send_px(input int x, input int y, input logic [15:0] d);
    pixel_valid_in = 1'b1;
    hcount_in      = x[7:0];
    vcount_in      = y[8:0];
    pixel_data_in  = d;
    model_px(x, y, d);
    tick();
    pixel_valid_in = 1'b0;
  endtask

  // each row: column 0 dark, a 4-pixel run on each side, dark pixels around the right run
  task automatic send_rect(input int x0, input int x1, input int y0, input int y1,
                           input logic [15:0] d);
    for (int y = y0; y <= y1; y++) begin
      send_px(0, y, DARK);
      for (int x = x0; x < x0 + 4; x++) send_px(x, y, d);
      send_px(x1 - 4, y, DARK);
      for (int x = x1 - 3; x <= x1; x++) send_px(x, y, d);
      if (x1 + 1 < WIDTH) send_px(x1 + 1, y, DARK);
    end
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    m_accum = 1'b1;
    m_clear();
  endtask

  task automatic end_frame(input bit busy, input bit with_start);
    bit valid;
    frame_end_in   = 1'b1;
    frame_start_in = with_start;
    busy_in        = busy;
    tick();
    frame_end_in   = 1'b0;
    frame_start_in = 1'b0;
    if (m_accum) begin
      m_accum = 1'b0;
      valid = (m_maxx >= 0) && (m_maxx - m_minx + 1 >= MIN_W) && (m_maxy - m_miny + 1 >= MIN_H);
      repeat (4) tick();
      if (valid && !busy) begin
        e_left  = m_minx[7:0];
        e_right = m_maxx[7:0];
        e_top   = m_miny[8:0];
        e_bot   = m_maxy[8:0];
        e_start = 1'b1;
        e_found = 1'b1;
      end else if (valid) begin
        e_found = 1'b1;
        if (e_drop != 8'd255) e_drop = e_drop + 8'd1;
      end else begin
        e_found = 1'b0;
      end
      tick();
      e_start = 1'b0;
    end else begin
      repeat (6) tick();
    end
    busy_in = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst_in  = 1'b0;
    e_left  = '0; e_right = '0; e_top = '0; e_bot = '0;
    e_start = 1'b0; e_found = 1'b0; e_drop = '0;
    m_accum = 1'b0;
    m_run   = 0;
    m_clear();
  endtask

  initial begin
    apply_reset();
    tick();
    chk_en = 1'b1;
    chk_box("reset", 0, 0, 0, 0, 1'b0);
    chk("reset_start", 32'(start_flag), 32'd0);
    chk("reset_drop",  32'(drop_cnt),   32'd0);
    tick();
    rst_in = 1'b1;
    tick();

    // end pulse and bright pixel while idle are ignored
    send_px(2, 2, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("idle", 0, 0, 0, 0, 1'b0);

    // main rectangle
    start_frame();
    send_rect(40, 199, 60, 259, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("rect", 40, 199, 60, 259, 1'b1);

    // all-dark frame: edges hold, box_found drops
    start_frame();
    send_px(0, 10, DARK);
    send_px(100, 100, DARK);
    end_frame(1'b0, 1'b0);
    chk_box("dark", 40, 199, 60, 259, 1'b0);

    // isolated speck at (5,5)
    start_frame();
    send_px(0, 5, DARK);
    send_px(5, 5, BRIGHT);
    send_px(6, 5, DARK);
    send_rect(40, 199, 60, 259, BRIGHT);
    end_frame(1'b0, 1'b0);
`ifdef CARD_BBOX_RUN_FILTER_EN
    chk_box("speck", 40, 199, 60, 259, 1'b1);
`else
    chk_box("speck", 5, 199, 5, 259, 1'b1);
`endif

    // two valid frames dropped while downstream is busy
    start_frame();
    send_rect(40, 199, 60, 259, BRIGHT);
    end_frame(1'b1, 1'b0);
    chk("busy1_drop",  32'(drop_cnt),  32'd1);
    chk("busy1_found", 32'(box_found), 32'd1);
    start_frame();
    send_rect(40, 199, 60, 259, BRIGHT);
    end_frame(1'b1, 1'b0);
    chk("busy2_drop", 32'(drop_cnt), 32'd2);
`ifdef CARD_BBOX_RUN_FILTER_EN
    chk("busy2_left", 32'(left_edge), 32'd40);
`else
    chk("busy2_left", 32'(left_edge), 32'd5);
`endif

    // 10x10 square is too small
    start_frame();
    send_rect(100, 109, 150, 159, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk("small_found", 32'(box_found), 32'd0);

    // exactly 32x32 at threshold luma, with a sub-threshold distractor row; start lost with end
    start_frame();
    send_px(0, 90, DARK);
    for (int x = 1; x <= 8; x++) send_px(x, 90, L149);
    send_rect(10, 41, 100, 131, L150);
    end_frame(1'b0, 1'b1);
    chk_box("thresh", 10, 41, 100, 131, 1'b1);
    send_rect(100, 139, 20, 59, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("lost_start", 10, 41, 100, 131, 1'b1);

    // 31 wide, then 31 high: both rejected
    start_frame();
    send_rect(10, 40, 100, 131, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("w31", 10, 41, 100, 131, 1'b0);
    start_frame();
    send_rect(10, 41, 100, 130, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("h31", 10, 41, 100, 130 + 1, 1'b0);

    // asynchronous reset mid-frame
    start_frame();
    send_rect(40, 199, 60, 70, BRIGHT);
    apply_reset();
    #2;
    chk_box("async_rst", 0, 0, 0, 0, 1'b0);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();

    // second start discards the partial frame
    start_frame();
    send_rect(150, 170, 200, 210, BRIGHT);
    start_frame();
    send_rect(20, 59, 20, 59, BRIGHT);
    end_frame(1'b0, 1'b0);
    chk_box("restart", 20, 59, 20, 59, 1'b1);

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
